// File: rtl/gpio_input_sampler.sv
// GPIO input sampler: two-flop synchronizer, optional per-bit debounce filter,
// rise/fall edge capture into a write-1-to-clear status register, and an OR-reduced irq.
module gpio_input_sampler #(
  parameter int NUMGPIO  = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [NUMGPIO-1:0] pinsIn,
  input  logic [NUMGPIO-1:0] dbEnable,
  input  logic [NUMGPIO-1:0] riseEn,
  input  logic [NUMGPIO-1:0] fallEn,
  input  logic               clearValid,
  input  logic [NUMGPIO-1:0] clearMask,
  output logic [NUMGPIO-1:0] level,
  output logic [NUMGPIO-1:0] status,
  output logic               irq
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE - 1);

  logic [NUMGPIO-1:0]         sync1_q, sync2_q;
  logic [NUMGPIO-1:0]         filt_q, filt_d;
  logic [NUMGPIO-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUMGPIO-1:0]         status_q, status_d;
  logic [NUMGPIO-1:0]         rise, fall, set_evt, clr_evt;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < NUMGPIO; i++) begin
      // bypassed bits follow sync2 directly and keep no partial count
      if (!dbEnable[i]) begin
        filt_d[i] = sync2_q[i];
      end else if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        filt_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // edges are taken from the filter's next value so status sets with level
  assign rise     = filt_d & ~filt_q;
  assign fall     = ~filt_d & filt_q;
  assign set_evt  = (rise & riseEn) | (fall & fallEn);
  assign clr_evt  = clearValid ? clearMask : '0;
  assign status_d = (status_q & ~clr_evt) | set_evt;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      sync1_q  <= pinsIn;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
    end
  end

  assign level  = filt_q;
  assign status = status_q;
  assign irq    = |status_q;

endmodule

// File: tb/tb_gpio_input_sampler.sv
// Directed bench for gpio_input_sampler; a DEBOUNCE=4 and a DEBOUNCE=8 instance share stimulus.
module tb_gpio_input_sampler;

  logic       clock = 1'b0;
  logic       resetN;
  logic [7:0] pinsIn, dbEnable, riseEn, fallEn, clearMask;
  logic       clearValid;
  logic [7:0] level4, status4, level8, status8;
  logic       irq4, irq8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  gpio_input_sampler #(.NUMGPIO(8), .DEBOUNCE(4)) u_dut (
    .clock(clock), .resetN(resetN), .pinsIn(pinsIn), .dbEnable(dbEnable),
    .riseEn(riseEn), .fallEn(fallEn), .clearValid(clearValid), .clearMask(clearMask),
    .level(level4), .status(status4), .irq(irq4)
  );

  gpio_input_sampler #(.NUMGPIO(8), .DEBOUNCE(8)) u_dut8 (
    .clock(clock), .resetN(resetN), .pinsIn(pinsIn), .dbEnable(dbEnable),
    .riseEn(riseEn), .fallEn(fallEn), .clearValid(clearValid), .clearMask(clearMask),
    .level(level8), .status(status8), .irq(irq8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, leaving time 1 unit past the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_all();
    clearValid = 1'b1;
    clearMask  = 8'hFF;
    step(1);
    clearValid = 1'b0;
    clearMask  = 8'h00;
  endtask

  initial begin
    resetN     = 1'b0;
    pinsIn     = 8'hFF;
    dbEnable   = 8'hFF;
    riseEn     = 8'hFF;
    fallEn     = 8'h00;
    clearValid = 1'b0;
    clearMask  = 8'h00;

    // reset with pins high, then release and watch the debounced rise
    step(3);
    check("rst_level", level4, 8'h00);
    check("rst_status", status4, 8'h00);
    check("rst_irq", irq4, 1'b0);
    resetN = 1'b1;
    step(5);
    check("rel_level_e5", level4, 8'h00);
    step(1);
    check("rel_level_e6", level4, 8'hFF);
    check("rel_status_e6", status4, 8'hFF);
    check("rel_irq_e6", irq4, 1'b1);
    clear_all();
    check("clr_status", status4, 8'h00);
    check("clr_irq", irq4, 1'b0);

    // bypass latency
    dbEnable = 8'h00;
    riseEn   = 8'h00;
    pinsIn   = 8'h00;
    step(3);
    check("byp_settle_level", level4, 8'h00);
    check("byp_settle_status", status4, 8'h00);
    riseEn = 8'h01;
    pinsIn = 8'h01;
    step(2);
    check("byp_level_e2", level4, 8'h00);
    check("byp_irq_e2", irq4, 1'b0);
    step(1);
    check("byp_level_e3", level4, 8'h01);
    check("byp_status_e3", status4, 8'h01);
    check("byp_irq_e3", irq4, 1'b1);
    pinsIn = 8'h00;
    step(3);
    check("byp_fall_level", level4, 8'h00);
    check("byp_fall_status", status4, 8'h01);
    clear_all();

    // glitch rejection on bit 2
    dbEnable = 8'h04;
    riseEn   = 8'h04;
    pinsIn   = 8'h04;
    step(3);
    pinsIn = 8'h00;
    step(6);
    check("glitch_level", level4, 8'h00);
    check("glitch_status", status4, 8'h00);
    pinsIn = 8'h04;
    step(5);
    check("db_level_e5", level4, 8'h00);
    step(1);
    check("db_level_e6", level4, 8'h04);
    check("db_status_e6", status4, 8'h04);
    clear_all();

    // set/clear collision
    dbEnable = 8'h00;
    riseEn   = 8'h0A;
    pinsIn   = 8'h06;
    step(3);
    check("coll_pre_status", status4, 8'h02);
    pinsIn = 8'h0E;
    step(2);
    clearValid = 1'b1;
    clearMask  = 8'h0A;
    step(1);
    clearValid = 1'b0;
    clearMask  = 8'h00;
    check("coll_status", status4, 8'h08);
    check("coll_irq", irq4, 1'b1);

    // multi-bit independence
    riseEn = 8'h00;
    fallEn = 8'h00;
    pinsIn = 8'h0F;
    step(3);
    clear_all();
    check("multi_pre_level", level4, 8'h0F);
    riseEn = 8'h55;
    fallEn = 8'hAA;
    pinsIn = 8'h5A;
    step(3);
    check("multi1_level", level4, 8'h5A);
    check("multi1_status", status4, 8'h50);
    pinsIn = 8'hF0;
    step(3);
    check("multi2_level", level4, 8'hF0);
    check("multi2_status", status4, 8'h5A);

    // reset mid-count on the DEBOUNCE=8 instance
    dbEnable = 8'hFF;
    riseEn   = 8'hFF;
    fallEn   = 8'h00;
    pinsIn   = 8'h00;
    step(12);
    clear_all();
    check("mid_pre_level8", level8, 8'h00);
    pinsIn = 8'hFF;
    step(5);
    #2;
    resetN = 1'b0;
    #1;
    check("mid_rst_level8", level8, 8'h00);
    check("mid_rst_status8", status8, 8'h00);
    check("mid_rst_irq8", irq8, 1'b0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    step(9);
    check("mid_level8_e9", level8, 8'h00);
    step(1);
    check("mid_level8_e10", level8, 8'hFF);
    check("mid_status8_e10", status8, 8'hFF);
    check("mid_irq8_e10", irq8, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_input_sampler.md
# gpio_input_sampler

Input-side companion to the GPIO tristate pad block. It takes the raw pin values read back from the pads, synchronizes them into the `clock` domain, and optionally debounces each bit. It then detects rising and falling edges and latches them into a write-1-to-clear status register that drives a single interrupt line. It sits between the pad wrapper's read-back bus and the GPIO register file / interrupt controller.

## Interface
Parameters:
- NUMGPIO, 8, number of GPIO bits handled.
- DEBOUNCE, 4, number of consecutive cycles a synchronized input must differ from the filtered value before the filtered value follows it.
  - Legal range is 1..65535.
  - The counter width is max(1, clog2(DEBOUNCE)).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- resetN  input  1  reset, asynchronous, active-low.
- pinsIn  input  NUMGPIO  raw pad values, asynchronous to `clock`.
- dbEnable  input  NUMGPIO  per-bit debounce enable; 0 bypasses the debouncer.
- riseEn  input  NUMGPIO  per-bit enable for latching rising edges into status.
- fallEn  input  NUMGPIO  per-bit enable for latching falling edges into status.
- clearValid  input  1  single-cycle strobe qualifying clearMask.
- clearMask  input  NUMGPIO  write-1-to-clear mask for status.
- level  output  NUMGPIO  filtered pin value.
- status  output  NUMGPIO  latched edge-event flags.
- irq  output  1  OR of all status bits.

## Operation
- **Synchronizer:** two flops per bit, sync1 <= pinsIn, then sync2 <= sync1.
- **Debounce, dbEnable[i]=1:** per-bit counter cnt[i] and filtered bit filt[i]. On each edge:
  - If sync2[i]==filt[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE-1: filt[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE cycles returns cnt to 0 and leaves filt unchanged.
- **Debounce, dbEnable[i]=0:** filt[i] <= sync2[i] every edge and cnt[i] <= 0.
  - Toggling dbEnable mid-count discards the partial count.
- **Edge events:**
  - rise[i] is true when filt[i] goes 0->1 on this edge; fall[i] is true when it goes 1->0.
  - On the same edge the bit is set: status[i] <= 1 if (rise[i]&riseEn[i]) | (fall[i]&fallEn[i]).
- **Clear:** if clearValid and clearMask[i], status[i] <= 0.
  - Set and clear on the same edge: set wins, and status[i] stays 1.
  - Disabling riseEn/fallEn does not clear bits that are already set.
- **Outputs:**
  - level = filt, registered.
  - status is registered.
  - irq = |status, combinational from the status flops, so no extra cycle.
- **Reset (asynchronous assert, any time, including mid-count):** sync1, sync2, filt, cnt and status all go to 0.
  - Outputs during and after reset: level=0, status=0, irq=0.
  - After release, a pin held high propagates through normally and produces a rising edge, which sets status if riseEn is set.

## Timing
- Pin change stable before edge E1: sync1 updates at E1, sync2 at E2.
- Bypass mode: filt/level updates at E3, and status/irq assert at E3. Latency is 3 edges.
- Debounce mode, input stable throughout: filt updates at edge E(2+DEBOUNCE). DEBOUNCE=1 matches bypass.
- clearValid sampled at edge Ec clears status at Ec, so irq deasserts after Ec unless a set occurs on the same edge.
- No handshake: clearValid is a one-cycle write strobe from the register file; holding it high clears on every edge.
- Bits are fully independent; no cross-bit ordering is implied.

## Test plan
- **Reset:** resetN=0 with pinsIn=8'hFF, then release at edge 0 with DEBOUNCE=4, dbEnable=8'hFF, riseEn=8'hFF -> level=0/status=0 during reset; level=8'hFF and status=8'hFF at edge 6; irq=1.
- **Bypass latency:** dbEnable=0, riseEn[0]=1, pinsIn[0] 0->1 before E1 -> level[0]=1 and status[0]=1 exactly after E3, irq=1; with fallEn[0]=0, pinsIn[0] 1->0 gives level[0]=0 after 3 edges and status unchanged.
- **Glitch reject:** DEBOUNCE=4, dbEnable[2]=1, pinsIn[2] high for 3 cycles then low -> level[2] stays 0, status[2]=0; holding high for 4+ cycles -> level[2]=1 at E6.
- **Set/clear collision:** status[1]=1, rising edge on bit 3 (riseEn[3]=1) on the same edge as clearValid=1 with clearMask=8'h0A -> status=8'h08 and irq=1; a collision on one bit keeps that bit set.
- **Reset mid-count:** DEBOUNCE=8, pin high for 5 cycles, then resetN pulsed low asynchronously between edges -> all outputs 0 immediately; after release the count restarts from 0 and level rises DEBOUNCE+2 edges after release.
- **Multi-bit independence:** NUMGPIO=8, alternating bits toggled with mixed riseEn=8'h55 / fallEn=8'hAA -> status reflects only the enabled edge per bit, and level tracks every bit.
